// File: rtl/mc_main_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mc_main_control
// Purpose  : Multicycle main control FSM. Sequences FETCH / DECODE / EXEC /
//            MEM / WB for R-type, LW, SW, BEQ and JMP, runs RSWP as two
//            register writes (SWAP1, SWAP2), handshakes with a shared memory
//            through mem_req/mem_ready and counts retired instructions.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   run                   level, keep fetching while high
//   clr_err               pulse, clears illegal/timeout (a new set wins)
//   opcode, func          IR fields, valid from DECODE onward
//   zero                  ALU zero flag (BEQ)
//   mem_ready             memory completes the current request this cycle
//   mem_req, iord         memory request / address select (0 PC, 1 ALU)
//   ir_load, pc_write     IR and PC load enables
//   pc_src                00 PC+4, 01 branch target, 10 jump target
//   alusrc .. mem2reg     datapath controls as in the single-cycle decoder
//   swap, swap_phase      RSWP writeback in progress / which half
//   aluop                 ALU operation (all ones when unused, zero in IDLE)
//   busy                  FSM not in IDLE
//   illegal, timeout      sticky error flags
//   instr_count           retired instructions, wraps
// Build option
//   MEM_TIMEOUT_EN        adds a memory wait counter; a wait of MEM_WAIT_MAX
//                         cycles without mem_ready aborts to IDLE and sets
//                         timeout. Undefined: waits forever, timeout = 0.
// ============================================================================
module mc_main_control #(
    parameter int ALUOP_W      = 4,
    parameter int CNT_W        = 16,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               clr_err,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               iord,
    output logic               ir_load,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               alusrc,
    output logic               extop,
    output logic               regdst,
    output logic               regwrite,
    output logic               memwrite,
    output logic               mem2reg,
    output logic               swap,
    output logic               swap_phase,
    output logic [ALUOP_W-1:0] aluop,
    output logic               busy,
    output logic               illegal,
    output logic               timeout,
    output logic [CNT_W-1:0]   instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_SWAP1  = 3'd6;
    localparam logic [2:0] S_SWAP2  = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JMP   = 6'b000010;
    localparam logic [5:0] OP_RSWP  = 6'b100000;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    logic [2:0] state;
    logic [2:0] next_state;
    logic [5:0] op_q;
    logic [5:0] func_q;
    logic       finish;
    logic       set_illegal;
    logic       set_timeout;
    logic       wait_expired;
    logic       func_legal;

    assign func_legal = (func == F_ADD) || (func == F_SUB) || (func == F_AND) ||
                        (func == F_OR)  || (func == F_SLT);

`ifdef MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              in_wait;

    assign in_wait = (state == S_FETCH) || (state == S_MEM);
    // Counter holds the number of wait cycles already spent, so the cycle in
    // which it equals MAX-1 with no ready is the MAX-th cycle of waiting.
    assign wait_expired = in_wait && !mem_ready &&
                          (wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (in_wait && !mem_ready && !wait_expired)
            wait_cnt <= wait_cnt + WAIT_W'(1);
        else
            wait_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timeout <= 1'b0;
        else
            timeout <= set_timeout | (timeout & ~clr_err);
    end
`else
    logic unused_wait_cfg;
    assign unused_wait_cfg = (MEM_WAIT_MAX != 0);
    assign wait_expired    = 1'b0;
    assign timeout         = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state  = state;
        finish      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_IDLE:   if (run) next_state = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    next_state = S_DECODE;
                end else if (wait_expired) begin
                    next_state  = S_IDLE;
                    set_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (func_legal) next_state = S_EXEC;
                        else            set_illegal = 1'b1;
                    end
                    OP_LW, OP_SW, OP_BEQ: next_state = S_EXEC;
                    OP_JMP:               finish     = 1'b1;
                    OP_RSWP:              next_state = S_SWAP1;
                    default:              set_illegal = 1'b1;
                endcase
                if (set_illegal) next_state = S_IDLE;
            end
            S_EXEC: begin
                case (op_q)
                    OP_RTYPE:     next_state = S_WB;
                    OP_LW, OP_SW: next_state = S_MEM;
                    OP_BEQ:       finish     = 1'b1;
                    default:      next_state = S_IDLE;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op_q == OP_SW) finish     = 1'b1;
                    else               next_state = S_WB;
                end else if (wait_expired) begin
                    next_state  = S_IDLE;
                    set_timeout = 1'b1;
                end
            end
            S_WB:     finish     = 1'b1;
            S_SWAP1:  next_state = S_SWAP2;
            S_SWAP2:  finish     = 1'b1;
            default:  next_state = S_IDLE;
        endcase
        // A retiring instruction always completes; run only picks what follows.
        if (finish) next_state = run ? S_FETCH : S_IDLE;
    end

    // Output decode. DECODE looks at the live IR fields because op_q is only
    // loaded at the end of that cycle; later states use the latched copy.
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alusrc     = 1'b0;
        extop      = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        mem2reg    = 1'b0;
        swap       = 1'b0;
        swap_phase = 1'b0;
        // IDLE is the reset state, so every output there is zero.
        aluop      = (state == S_IDLE) ? '0 : '1;
        busy       = (state != S_IDLE);
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                if (opcode == OP_JMP) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_RTYPE: begin
                        case (func_q)
                            F_ADD:   aluop = ALUOP_W'(4'b0010);
                            F_SUB:   aluop = ALUOP_W'(4'b0110);
                            F_AND:   aluop = ALUOP_W'(4'b0000);
                            F_OR:    aluop = ALUOP_W'(4'b0001);
                            F_SLT:   aluop = ALUOP_W'(4'b0111);
                            default: aluop = '1;
                        endcase
                    end
                    OP_LW, OP_SW: begin
                        alusrc = 1'b1;
                        extop  = 1'b1;
                        aluop  = ALUOP_W'(4'b0010);
                    end
                    OP_BEQ: begin
                        extop    = 1'b1;
                        aluop    = ALUOP_W'(4'b0110);
                        pc_src   = 2'b01;
                        pc_write = zero;
                    end
                    default: aluop = '1;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = (op_q == OP_SW);
            end
            S_WB: begin
                regwrite = 1'b1;
                mem2reg  = (op_q == OP_LW);
                regdst   = (op_q != OP_LW);
            end
            S_SWAP1: begin
                swap     = 1'b1;
                regwrite = 1'b1;
            end
            S_SWAP2: begin
                swap       = 1'b1;
                swap_phase = 1'b1;
                regwrite   = 1'b1;
            end
            default: busy = (state != S_IDLE);
        endcase
    end

    // Instruction field latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 6'd0;
            func_q <= 6'd0;
        end else if (state == S_DECODE) begin
            op_q   <= opcode;
            func_q <= func;
        end
    end

    // Sticky illegal flag; a new set outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal <= 1'b0;
        else
            illegal <= set_illegal | (illegal & ~clr_err);
    end

    // Retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instr_count <= '0;
        else if (finish)
            instr_count <= instr_count + CNT_W'(1);
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_main_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mc_main_control
// Purpose  : Directed self-checking bench for mc_main_control. Each task
//            steps one scenario cycle by cycle, driving inputs at the falling
//            edge and comparing outputs 1 ns later against hand-derived
//            vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_main_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_JMP  = 6'b000010;
    localparam logic [5:0] OP_RSWP = 6'b100000;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;

    // Bit positions inside the packed control view "ctl" below
    localparam logic [14:0] B_BUSY = 15'h0001;
    localparam logic [14:0] B_SPH  = 15'h0002;
    localparam logic [14:0] B_SWAP = 15'h0004;
    localparam logic [14:0] B_M2R  = 15'h0008;
    localparam logic [14:0] B_MW   = 15'h0010;
    localparam logic [14:0] B_RW   = 15'h0020;
    localparam logic [14:0] B_RD   = 15'h0040;
    localparam logic [14:0] B_EXT  = 15'h0080;
    localparam logic [14:0] B_ASRC = 15'h0100;
    localparam logic [14:0] B_PCBR = 15'h0200;
    localparam logic [14:0] B_PCJ  = 15'h0400;
    localparam logic [14:0] B_PCW  = 15'h0800;
    localparam logic [14:0] B_IRL  = 15'h1000;
    localparam logic [14:0] B_IORD = 15'h2000;
    localparam logic [14:0] B_MREQ = 15'h4000;
    localparam logic [14:0] C_FETCH = B_MREQ | B_IRL | B_PCW | B_BUSY;
    localparam logic [14:0] C_MWAIT = B_MREQ | B_IORD | B_BUSY;

    logic        clk;
    logic        rst_n, run, clr_err, zero, mem_ready;
    logic [5:0]  opcode, func;
    logic        mem_req, iord, ir_load, pc_write, alusrc, extop, regdst;
    logic        regwrite, memwrite, mem2reg, swap, swap_phase, busy;
    logic        illegal, timeout;
    logic [1:0]  pc_src;
    logic [3:0]  aluop;
    logic [15:0] instr_count;
    logic [14:0] ctl;

    int checks = 0;
    int errors = 0;

    mc_main_control #(.ALUOP_W(4), .CNT_W(16), .MEM_WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .clr_err(clr_err),
        .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .ir_load(ir_load), .pc_write(pc_write),
        .pc_src(pc_src), .alusrc(alusrc), .extop(extop), .regdst(regdst),
        .regwrite(regwrite), .memwrite(memwrite), .mem2reg(mem2reg),
        .swap(swap), .swap_phase(swap_phase), .aluop(aluop), .busy(busy),
        .illegal(illegal), .timeout(timeout), .instr_count(instr_count)
    );

    assign ctl = {mem_req, iord, ir_load, pc_write, pc_src, alusrc, extop, regdst,
                  regwrite, memwrite, mem2reg, swap, swap_phase, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        @(negedge clk); #1;
        checks++; if (ctl !== 15'd0) begin errors++; $display("FAIL reset ctl: got %b want 0", ctl); end
        checks++; if (aluop !== 4'd0) begin errors++; $display("FAIL reset aluop: got %b want 0000", aluop); end
        checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL reset count: got %0d want 0", instr_count); end
        checks++; if ({illegal, timeout} !== 2'b00) begin errors++; $display("FAIL reset flags: got %b want 00", {illegal, timeout}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ADD from IDLE: IDLE, FETCH, DECODE, EXEC, WB
    task automatic test_add;
        logic [14:0] ec [5];
        logic [3:0]  ea [5];
        ec = '{15'd0, C_FETCH, B_BUSY, B_BUSY, B_RW | B_RD | B_BUSY};
        ea = '{4'b0000, 4'b1111, 4'b1111, 4'b0010, 4'b1111};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            run = 1'b1; opcode = OP_R; func = F_ADD; mem_ready = 1'b1;
            #1;
            checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL add ctl cyc %0d: got %b want %b", i, ctl, ec[i]); end
            checks++; if (aluop !== ea[i]) begin errors++; $display("FAIL add aluop cyc %0d: got %b want %b", i, aluop, ea[i]); end
        end
    endtask

    // LW with three wait cycles in MEM: 8 cycles total
    task automatic test_lw;
        logic [14:0] ec [8];
        logic        rdy [8];
        ec  = '{C_FETCH, B_BUSY, B_ASRC | B_EXT | B_BUSY, C_MWAIT, C_MWAIT, C_MWAIT,
                C_MWAIT, B_RW | B_M2R | B_BUSY};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            opcode = OP_LW; func = 6'd0; mem_ready = rdy[i];
            #1;
            checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL lw ctl cyc %0d: got %b want %b", i, ctl, ec[i]); end
            if (i == 0) begin
                checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL lw count: got %0d want 1", instr_count); end
            end
            if (i == 2) begin
                checks++; if (aluop !== 4'b0010) begin errors++; $display("FAIL lw aluop: got %b want 0010", aluop); end
            end
        end
    endtask

    task automatic test_sw;
        logic [14:0] ec [4];
        ec = '{C_FETCH, B_BUSY, B_ASRC | B_EXT | B_BUSY, C_MWAIT | B_MW};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            opcode = OP_SW; mem_ready = 1'b1;
            #1;
            checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL sw ctl cyc %0d: got %b want %b", i, ctl, ec[i]); end
            if (i == 0) begin
                checks++; if (instr_count !== 16'd2) begin errors++; $display("FAIL sw count: got %0d want 2", instr_count); end
            end
        end
    endtask

    // BEQ taken then not taken; both retire
    task automatic test_beq;
        logic [14:0] ec [6];
        logic        zr [6];
        ec = '{C_FETCH, B_BUSY, B_EXT | B_PCBR | B_PCW | B_BUSY,
               C_FETCH, B_BUSY, B_EXT | B_PCBR | B_BUSY};
        zr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            opcode = OP_BEQ; zero = zr[i]; mem_ready = 1'b1;
            #1;
            checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL beq ctl cyc %0d: got %b want %b", i, ctl, ec[i]); end
            if (i == 2 || i == 5) begin
                checks++; if (aluop !== 4'b0110) begin errors++; $display("FAIL beq aluop cyc %0d: got %b want 0110", i, aluop); end
            end
            if (i == 3) begin
                checks++; if (instr_count !== 16'd4) begin errors++; $display("FAIL beq count: got %0d want 4", instr_count); end
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jmp;
        logic [14:0] ec [2];
        ec = '{C_FETCH, B_PCW | B_PCJ | B_BUSY};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            opcode = OP_JMP; mem_ready = 1'b1;
            #1;
            checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL jmp ctl cyc %0d: got %b want %b", i, ctl, ec[i]); end
            if (i == 0) begin
                checks++; if (instr_count !== 16'd5) begin errors++; $display("FAIL jmp count: got %0d want 5", instr_count); end
            end
        end
    endtask

    // RSWP, run dropped in SWAP2 so the FSM parks in IDLE afterwards
    task automatic test_rswp;
        logic [14:0] ec [5];
        ec = '{C_FETCH, B_BUSY, B_SWAP | B_RW | B_BUSY, B_SWAP | B_SPH | B_RW | B_BUSY, 15'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            opcode = OP_RSWP; mem_ready = 1'b1; run = (i < 3);
            #1;
            checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL rswp ctl cyc %0d: got %b want %b", i, ctl, ec[i]); end
            if (i == 0 || i == 4) begin
                checks++;
                if (instr_count !== ((i == 0) ? 16'd6 : 16'd7)) begin
                    errors++; $display("FAIL rswp count cyc %0d: got %0d want %0d", i, instr_count, (i == 0) ? 6 : 7);
                end
            end
        end
    endtask

    // Bad opcode, then bad R-type func with clr_err in the same cycle
    task automatic test_illegal;
        logic [14:0] ec [8];
        logic        eil [8];
        logic        rn [8];
        logic        cl [8];
        ec  = '{15'd0, C_FETCH, B_BUSY, 15'd0, C_FETCH, B_BUSY, 15'd0, 15'd0};
        eil = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        rn  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        cl  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            run = rn[i]; clr_err = cl[i]; mem_ready = 1'b1;
            opcode = (i < 3) ? 6'b111111 : OP_R;
            func   = 6'b000000;
            #1;
            checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL illegal ctl cyc %0d: got %b want %b", i, ctl, ec[i]); end
            checks++; if (illegal !== eil[i]) begin errors++; $display("FAIL illegal flag cyc %0d: got %b want %b", i, illegal, eil[i]); end
            checks++; if (instr_count !== 16'd7) begin errors++; $display("FAIL illegal count cyc %0d: got %0d want 7", i, instr_count); end
        end
        clr_err = 1'b0;
    endtask

    // run dropped while FETCH is still waiting; SUB must still complete
    task automatic test_run_drop;
        logic [14:0] ec [8];
        logic        rdy [8];
        ec  = '{15'd0, B_MREQ | B_BUSY, B_MREQ | B_BUSY, C_FETCH, B_BUSY, B_BUSY,
                B_RW | B_RD | B_BUSY, 15'd0};
        rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            run = (i == 0); opcode = OP_R; func = F_SUB; mem_ready = rdy[i];
            #1;
            checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL rundrop ctl cyc %0d: got %b want %b", i, ctl, ec[i]); end
            if (i == 5) begin
                checks++; if (aluop !== 4'b0110) begin errors++; $display("FAIL rundrop aluop: got %b want 0110", aluop); end
            end
        end
        checks++; if (instr_count !== 16'd8) begin errors++; $display("FAIL rundrop count: got %0d want 8", instr_count); end
    endtask

`ifdef MEM_TIMEOUT_EN
    // FETCH never answered: 15 wait cycles, then IDLE with timeout set
    task automatic test_timeout;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            run = (i == 0); opcode = OP_JMP; mem_ready = 1'b0; clr_err = (i == 16);
            #1;
            checks++;
            if (ctl !== ((i >= 1 && i <= 15) ? (B_MREQ | B_BUSY) : 15'd0)) begin
                errors++; $display("FAIL timeout ctl cyc %0d: got %b", i, ctl);
            end
            checks++;
            if (timeout !== (i == 16)) begin
                errors++; $display("FAIL timeout flag cyc %0d: got %b want %b", i, timeout, (i == 16));
            end
        end
        clr_err = 1'b0;
        checks++; if (instr_count !== 16'd8) begin errors++; $display("FAIL timeout count: got %0d want 8", instr_count); end
    endtask
`else
    // Without the timeout option a long FETCH wait simply continues
    task automatic test_timeout;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            run = (i == 0); opcode = OP_JMP; mem_ready = (i == 21);
            #1;
            checks++;
            if (ctl !== ((i == 0 || i == 23) ? 15'd0 :
                         (i == 21) ? C_FETCH :
                         (i == 22) ? (B_PCW | B_PCJ | B_BUSY) : (B_MREQ | B_BUSY))) begin
                errors++; $display("FAIL longwait ctl cyc %0d: got %b", i, ctl);
            end
            if (i == 20) begin
                checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL longwait timeout: got %b want 0", timeout); end
            end
        end
        checks++; if (instr_count !== 16'd9) begin errors++; $display("FAIL longwait count: got %0d want 9", instr_count); end
    endtask
`endif

    // Reset pulled between clock edges while LW waits in MEM
    task automatic test_async_reset;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            run = 1'b1; opcode = OP_LW; mem_ready = (i != 4);
            #1;
        end
        checks++; if (ctl !== C_MWAIT) begin errors++; $display("FAIL areset pre ctl: got %b want %b", ctl, C_MWAIT); end
        #1;
        rst_n = 1'b0; run = 1'b0;
        #1;
        checks++; if (ctl !== 15'd0) begin errors++; $display("FAIL areset ctl: got %b want 0", ctl); end
        checks++; if (aluop !== 4'd0) begin errors++; $display("FAIL areset aluop: got %b want 0000", aluop); end
        checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL areset count: got %0d want 0", instr_count); end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++; if (ctl !== 15'd0) begin errors++; $display("FAIL areset after ctl %0d: got %b want 0", i, ctl); end
        end
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; clr_err = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        opcode = 6'd0; func = 6'd0;
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_beq();
        test_jmp();
        test_rswp();
        test_illegal();
        test_run_drop();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
